tick_debouncer: RTL and testbench
=================================

TICK_DEBOUNCER -- requirements
Module: tick_debouncer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, giving the width of n_ticks and of the internal tick counter.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2 (legal 2..3), giving the number of input synchronizer flops.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port tick, input, 1 bit: one-cycle sample strobe from the upstream free-running tick generator.
REQ-006 The block SHALL have port btn_in, input, 1 bit: raw asynchronous button/switch level.
REQ-007 The block SHALL have port n_ticks, input, CNT_W bits: consecutive stable ticks required to accept a level change; sampled every cycle.
REQ-008 The block SHALL have port db_level, output, 1 bit: registered debounced level.
REQ-009 The block SHALL have port press, output, 1 bit: registered one-cycle pulse on accepted 0->1 change.
REQ-010 The block SHALL have port release, output, 1 bit: registered one-cycle pulse on accepted 1->0 change.

Function
REQ-011 btn_in SHALL pass through SYNC_STAGES flops; only the last stage output (btn_s) feeds the state machine.
REQ-012 The FSM SHALL have four states: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
REQ-013 LOW: btn_s=1 -> WAIT_HIGH with counter cleared to 0; else stay.
REQ-014 WAIT_HIGH: btn_s=0 -> LOW, counter cleared; else on tick=1 counter increments; when the incremented value equals the effective threshold -> HIGH.
REQ-015 HIGH: btn_s=0 -> WAIT_LOW, counter cleared; else stay.
REQ-016 WAIT_LOW: btn_s=1 -> HIGH, counter cleared; else on tick=1 counter increments; reaching threshold -> LOW.
REQ-017 Effective threshold SHALL be n_ticks, except n_ticks=0 SHALL be treated as 1.
REQ-018 btn_s reverting in the same cycle as tick=1 in a WAIT state: abort SHALL take priority; no count, no transition toward the new level.
REQ-019 Ticks in LOW or HIGH SHALL be ignored; counter holds 0.
REQ-020 db_level SHALL be 1 exactly when the FSM is in HIGH or WAIT_LOW.
REQ-021 press SHALL be 1 for exactly the one cycle following the edge at which WAIT_HIGH->HIGH occurs; release likewise for WAIT_LOW->LOW; db_level changes on that same edge.
REQ-022 Latency: from the clk edge sampling the final qualifying tick to the press/release/db_level change SHALL be exactly one edge (registered outputs, no combinational path from inputs).
REQ-023 press and release SHALL never be asserted in the same cycle; at most one pulse per accepted change.
REQ-024 The counter SHALL never wrap: if n_ticks is lowered below the current count mid-wait, the next tick SHALL complete the transition.
REQ-025 tick held high for multiple cycles SHALL count once per cycle it is high.

Reset
REQ-026 On reset=1, asynchronously: FSM=LOW, counter=0, synchronizer flops=0, db_level=0, press=0, release=0.
REQ-027 Reset asserted mid-wait SHALL discard partial counts; after release the block SHALL start from LOW regardless of btn_in.
REQ-028 Ticks present while reset=1 SHALL have no effect.

Structure
REQ-029 FSM state encodings (2-bit localparams LOW=0, WAIT_HIGH=1, HIGH=2, WAIT_LOW=3) SHALL live in shared package tick_debouncer_pkg.
REQ-030 The synchronizer SHALL be sub-module sync_ff (parameter STAGES, ports clk, reset, d, q), reusable elsewhere.
REQ-031 The block SHALL contain a single always block for state/counter and one for registered outputs; total RTL 120-400 lines.

Verification
REQ-032 Clean press: n_ticks=3, tick every 28 cycles, btn_in 0->1 held -> press one cycle after 3rd tick post-sync, db_level=1, release=0.
REQ-033 Bounce: n_ticks=3, btn_in high for 2 ticks then low 5 cycles -> no press, db_level stays 0, FSM back in LOW.
REQ-034 Release path: from HIGH, btn_in=0 for 3 ticks -> release one cycle pulse, db_level=0; press never asserted.
REQ-035 Tie case: btn_s drops in the cycle tick=1 on count 2 of 3 -> no press; counter 0.
REQ-036 n_ticks=0: btn_in high, first tick -> press, as for n_ticks=1.
REQ-037 Async reset mid-WAIT_HIGH (count=2) with btn_in still 1 -> outputs 0 immediately; after deassert, press only after 3 further ticks.

Source files
------------

// File: rtl/tick_debouncer_pkg.sv
// Shared state encoding for the tick-sampled button debouncer.
// The encoding is fixed so that other blocks and debug taps can decode the state.
package tick_debouncer_pkg;

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      WAIT_HIGH = 2'd1,
      HIGH      = 2'd2,
      WAIT_LOW  = 2'd3
   } db_state_t;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 3;

   // Debounced level implied by a state: high once a rise is accepted, until a fall is.
   function automatic logic state_level(input db_state_t s);
      return (s == HIGH) || (s == WAIT_LOW);
   endfunction

endpackage

// File: rtl/tick_debouncer_sync.sv
// Generic multi-flop level synchronizer for an asynchronous single-bit input.
// It clears to zero on reset, so a held input is re-acquired only after reset ends.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr <= '0;
      end else begin
         sr <= {sr[STAGES-2:0], d};
      end
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/tick_debouncer.sv
// Button/switch debouncer: a level change is accepted after n_ticks consecutive
// stable sample ticks; it emits a registered level plus press/release pulses.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   LOW       | debounced level 0, input agrees
//   WAIT_HIGH | level 0, input high; counting ticks toward accepting 1
//   HIGH      | debounced level 1, input agrees
//   WAIT_LOW  | level 1, input low; counting ticks toward accepting 0
module tick_debouncer
   import tick_debouncer_pkg::*;
#(
   parameter int CNT_W       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             btn_in,
   input  logic [CNT_W-1:0] n_ticks,
   output logic             db_level,
   output logic             press,
   output logic             release_pulse
);

   logic             btn_s;
   db_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] thresh;
   logic [CNT_W:0]   cnt_inc;
   logic             thresh_hit;
   logic             accept_high;
   logic             accept_low;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn_in),
      .q     (btn_s)
   );

   // Compare with >= on a widened count so lowering n_ticks mid-wait finishes on the next tick.
   always_comb begin
      thresh      = (n_ticks == '0) ? CNT_W'(1) : n_ticks;
      cnt_inc     = {1'b0, cnt} + (CNT_W+1)'(1);
      thresh_hit  = (cnt_inc >= {1'b0, thresh});
      accept_high = (state == WAIT_HIGH) && btn_s && tick && thresh_hit;
      accept_low  = (state == WAIT_LOW) && !btn_s && tick && thresh_hit;
   end

   // An input reverting during a wait wins over a coincident tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= LOW;
         cnt   <= '0;
      end else begin
         case (state)
            LOW: begin
               if (btn_s) begin
                  state <= WAIT_HIGH;
                  cnt   <= '0;
               end
            end
            WAIT_HIGH: begin
               if (!btn_s) begin
                  state <= LOW;
                  cnt   <= '0;
               end else if (tick) begin
                  if (thresh_hit) begin
                     state <= HIGH;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt_inc[CNT_W-1:0];
                  end
               end
            end
            HIGH: begin
               if (!btn_s) begin
                  state <= WAIT_LOW;
                  cnt   <= '0;
               end
            end
            WAIT_LOW: begin
               if (btn_s) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else if (tick) begin
                  if (thresh_hit) begin
                     state <= LOW;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt_inc[CNT_W-1:0];
                  end
               end
            end
            default: begin
               state <= LOW;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_level      <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         press         <= accept_high;
         release_pulse <= accept_low;
         if (accept_high) begin
            db_level <= 1'b1;
         end else if (accept_low) begin
            db_level <= 1'b0;
         end
      end
   end

   a_no_dual_pulse : assert property (@(posedge clk) disable iff (reset)
      !(press && release_pulse));

   a_level_tracks_state : assert property (@(posedge clk) disable iff (reset)
      db_level == state_level(state));

   a_cnt_idle_zero : assert property (@(posedge clk) disable iff (reset)
      ((state == LOW) || (state == HIGH)) |-> (cnt == '0));

endmodule

// File: tb/tb_tick_debouncer.sv
// Self-checking bench for tick_debouncer: a cycle table plus hand-written
// sequences for bounce, tie, lowered threshold and asynchronous reset.
module tb_tick_debouncer;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       btn_in;
   logic [3:0] n_ticks;
   logic       db_level;
   logic       press;
   logic       release_pulse;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       tick;
      logic       btn;
      logic [3:0] n;
      logic [2:0] exp;
   } vec_t;

   vec_t       tbl[$];
   logic [2:0] exp_q[$];

   always #5 clk = ~clk;

   tick_debouncer #(
      .CNT_W       (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .tick          (tick),
      .btn_in        (btn_in),
      .n_ticks       (n_ticks),
      .db_level      (db_level),
      .press         (press),
      .release_pulse (release_pulse)
   );

   task automatic compare(input string name);
      logic [2:0] e;
      logic [2:0] act;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e   = exp_q.pop_front();
         act = {db_level, press, release_pulse};
         n_vec++;
         if (act !== e) begin
            n_err++;
            $display("FAIL %s: db/press/rel got %b expected %b", name, act, e);
         end
      end
   endtask

   // Drive at a falling edge, let one rising edge sample, check at the next falling edge.
   task automatic step(input string name, input logic t, input logic b,
                       input logic [3:0] n, input logic [2:0] e);
      tick    = t;
      btn_in  = b;
      n_ticks = n;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      compare(name);
   endtask

   task automatic add(input logic t, input logic b, input logic [3:0] n, input logic [2:0] e);
      vec_t v;
      v.tick = t;
      v.btn  = b;
      v.n    = n;
      v.exp  = e;
      tbl.push_back(v);
   endtask

   initial begin
      reset   = 1'b1;
      tick    = 1'b0;
      btn_in  = 1'b0;
      n_ticks = 4'd3;
      repeat (2) @(negedge clk);
      exp_q.push_back(3'b000);
      compare("reset_state");
      step("reset_tick_ignored", 1'b1, 1'b1, 4'd3, 3'b000);
      step("reset_tick_ignored2", 1'b1, 1'b1, 4'd3, 3'b000);
      reset = 1'b0;
      step("idle0", 1'b1, 1'b0, 4'd3, 3'b000);
      step("idle1", 1'b0, 1'b0, 4'd3, 3'b000);
      step("idle2", 1'b0, 1'b0, 4'd3, 3'b000);

      // clean press, aborted release, release, lowered threshold, n_ticks=0 both ways
      add(0,1,3,3'b000); add(0,1,3,3'b000); add(1,1,3,3'b000); add(1,1,3,3'b000);
      add(0,1,3,3'b000); add(1,1,3,3'b000); add(1,1,3,3'b110); add(0,1,3,3'b100);
      add(0,0,3,3'b100); add(1,0,3,3'b100); add(1,0,3,3'b100); add(1,0,3,3'b100);
      add(1,1,3,3'b100); add(0,1,3,3'b100); add(1,1,3,3'b100); add(0,0,3,3'b100);
      add(0,0,3,3'b100); add(0,0,3,3'b100); add(1,0,3,3'b100); add(1,0,3,3'b100);
      add(1,0,3,3'b001); add(0,0,3,3'b000); add(0,1,3,3'b000); add(0,1,3,3'b000);
      add(0,1,3,3'b000); add(1,1,3,3'b000); add(1,1,3,3'b000); add(0,1,1,3'b000);
      add(1,1,1,3'b110); add(0,1,1,3'b100); add(0,0,0,3'b100); add(0,0,0,3'b100);
      add(0,0,0,3'b100); add(1,0,0,3'b001); add(0,0,0,3'b000); add(0,1,0,3'b000);
      add(0,1,0,3'b000); add(0,1,0,3'b000); add(1,1,0,3'b110); add(0,1,0,3'b100);
      add(0,0,3,3'b100); add(0,0,3,3'b100); add(0,0,3,3'b100); add(1,0,3,3'b100);
      add(1,0,3,3'b100); add(1,0,3,3'b001); add(0,0,3,3'b000);

      for (int i = 0; i < tbl.size(); i++) begin
         step($sformatf("vec%0d", i), tbl[i].tick, tbl[i].btn, tbl[i].n, tbl[i].exp);
      end

      // bounce: two ticks counted, then input drops before the third
      step("bounce_s1", 1'b0, 1'b1, 4'd3, 3'b000);
      step("bounce_s2", 1'b0, 1'b1, 4'd3, 3'b000);
      step("bounce_wh", 1'b0, 1'b1, 4'd3, 3'b000);
      step("bounce_c1", 1'b1, 1'b1, 4'd3, 3'b000);
      step("bounce_c2", 1'b1, 1'b1, 4'd3, 3'b000);
      for (int i = 0; i < 5; i++) begin
         step($sformatf("bounce_low%0d", i), (i >= 3) ? 1'b1 : 1'b0, 1'b0, 4'd3, 3'b000);
      end

      // tie: synchronized input drops on the same cycle as the tick that would make count 3
      step("tie_s1", 1'b0, 1'b1, 4'd3, 3'b000);
      step("tie_s2", 1'b0, 1'b1, 4'd3, 3'b000);
      step("tie_wh", 1'b0, 1'b1, 4'd3, 3'b000);
      step("tie_c1", 1'b1, 1'b1, 4'd3, 3'b000);
      step("tie_c2", 1'b1, 1'b0, 4'd3, 3'b000);
      step("tie_hold", 1'b0, 1'b0, 4'd3, 3'b000);
      step("tie_abort", 1'b1, 1'b0, 4'd3, 3'b000);
      step("tie_r_s1", 1'b0, 1'b1, 4'd3, 3'b000);
      step("tie_r_s2", 1'b0, 1'b1, 4'd3, 3'b000);
      step("tie_r_wh", 1'b0, 1'b1, 4'd3, 3'b000);
      step("tie_r_c1", 1'b1, 1'b1, 4'd3, 3'b000);
      step("tie_r_c2", 1'b1, 1'b1, 4'd3, 3'b000);
      step("tie_r_press", 1'b1, 1'b1, 4'd3, 3'b110);
      step("tie_r_after", 1'b0, 1'b0, 4'd3, 3'b100);
      step("tie_r_fall1", 1'b0, 1'b0, 4'd3, 3'b100);
      step("tie_r_fall2", 1'b0, 1'b0, 4'd3, 3'b100);
      step("tie_r_c1l", 1'b1, 1'b0, 4'd3, 3'b100);
      step("tie_r_c2l", 1'b1, 1'b0, 4'd3, 3'b100);
      step("tie_r_rel", 1'b1, 1'b0, 4'd3, 3'b001);
      step("tie_r_idle", 1'b0, 1'b0, 4'd3, 3'b000);

      // reset in WAIT_HIGH at count 2 with the button still held
      step("rst_wh_s1", 1'b0, 1'b1, 4'd3, 3'b000);
      step("rst_wh_s2", 1'b0, 1'b1, 4'd3, 3'b000);
      step("rst_wh_wh", 1'b0, 1'b1, 4'd3, 3'b000);
      step("rst_wh_c1", 1'b1, 1'b1, 4'd3, 3'b000);
      step("rst_wh_c2", 1'b1, 1'b1, 4'd3, 3'b000);
      reset = 1'b1;
      exp_q.push_back(3'b000);
      #1;
      compare("rst_wh_async");
      @(negedge clk);
      step("rst_wh_held0", 1'b1, 1'b1, 4'd3, 3'b000);
      step("rst_wh_held1", 1'b1, 1'b1, 4'd3, 3'b000);
      reset = 1'b0;
      step("rst_wh_r_s1", 1'b1, 1'b1, 4'd3, 3'b000);
      step("rst_wh_r_s2", 1'b1, 1'b1, 4'd3, 3'b000);
      step("rst_wh_r_wh", 1'b1, 1'b1, 4'd3, 3'b000);
      step("rst_wh_r_c1", 1'b1, 1'b1, 4'd3, 3'b000);
      step("rst_wh_r_c2", 1'b1, 1'b1, 4'd3, 3'b000);
      step("rst_wh_r_press", 1'b1, 1'b1, 4'd3, 3'b110);
      step("rst_wh_r_high", 1'b0, 1'b1, 4'd3, 3'b100);

      // reset while HIGH must drop db_level without waiting for a clock edge
      reset = 1'b1;
      exp_q.push_back(3'b000);
      #1;
      compare("rst_high_async");
      @(negedge clk);
      step("rst_high_held", 1'b1, 1'b1, 4'd3, 3'b000);
      reset = 1'b0;
      step("rst_high_after", 1'b0, 1'b0, 4'd3, 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
